// File: rtl/program_loader_ctrl.sv
// Job sequencer for processor_top: loads instruction and data memory while the
// core is held in reset, releases the core until it reports done (or the cycle
// budget runs out), then streams a window of data memory out over valid/ready.
module program_loader_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  inst_count,
    input  logic [CNT_W-1:0]  data_count,
    input  logic [CNT_W-1:0]  read_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              proc_rst,
    output logic [DATA_W-1:0] inst_data_out,
    output logic [ADDR_W-1:0] inst_addr_out,
    output logic              inst_we,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] proc_out,
    input  logic              proc_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              job_done,
    output logic              timeout
);

    localparam int unsigned CYC_W = $clog2(MAX_CYCLES + 1);
    localparam int unsigned LAT_W = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadInst,
        StLoadData,
        StRun,
        StReadWait,
        StReadOut,
        StFinish
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] data_cnt;
    logic [CNT_W-1:0] read_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [LAT_W-1:0] lat_cnt;

    // Host stream is only accepted while a load state is active.
    assign in_ready = (state == StLoadInst) || (state == StLoadData);
    assign busy     = (state != StIdle);

    // Main sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= StIdle;
            k             <= '0;
            inst_cnt      <= '0;
            data_cnt      <= '0;
            read_cnt      <= '0;
            cyc_cnt       <= '0;
            lat_cnt       <= '0;
            proc_rst      <= 1'b1;
            inst_data_out <= '0;
            inst_addr_out <= '0;
            inst_we       <= 1'b0;
            mem_data_out  <= '0;
            mem_addr_out  <= '0;
            mem_we        <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            job_done      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            // Strobes and pulse default low; counters restart outside their states.
            inst_we  <= 1'b0;
            mem_we   <= 1'b0;
            job_done <= 1'b0;
            cyc_cnt  <= '0;
            lat_cnt  <= '0;

            unique case (state)
                StIdle: begin
                    proc_rst <= 1'b1;
                    if (start) begin
                        inst_cnt <= inst_count;
                        data_cnt <= data_count;
                        read_cnt <= read_count;
                        timeout  <= 1'b0;
                        k        <= '0;
                        if (inst_count != '0) begin
                            state <= StLoadInst;
                        end else if (data_count != '0) begin
                            state <= StLoadData;
                        end else begin
                            state <= StRun;
                        end
                    end
                end

                StLoadInst: begin
                    if (in_valid) begin
                        inst_we       <= 1'b1;
                        inst_addr_out <= ADDR_W'(k);
                        inst_data_out <= in_data;
                        if (k == inst_cnt - CNT_W'(1)) begin
                            k     <= '0;
                            state <= (data_cnt != '0) ? StLoadData : StRun;
                        end else begin
                            k <= k + CNT_W'(1);
                        end
                    end
                end

                StLoadData: begin
                    if (in_valid) begin
                        mem_we       <= 1'b1;
                        mem_addr_out <= ADDR_W'(k);
                        mem_data_out <= in_data;
                        if (k == data_cnt - CNT_W'(1)) begin
                            k     <= '0;
                            state <= StRun;
                        end else begin
                            k <= k + CNT_W'(1);
                        end
                    end
                end

                // proc_rst drops one cycle after entry so the final load strobe
                // lands while the core is still held in reset.
                StRun: begin
                    proc_rst <= 1'b0;
                    cyc_cnt  <= cyc_cnt + CYC_W'(1);
                    if (proc_done) begin
                        k            <= '0;
                        mem_addr_out <= '0;
                        if (read_cnt != '0) begin
                            state <= StReadWait;
                        end else begin
                            state    <= StFinish;
                            job_done <= 1'b1;
                            proc_rst <= 1'b1;
                        end
                    end else if (cyc_cnt == CYC_W'(MAX_CYCLES - 1)) begin
                        timeout  <= 1'b1;
                        state    <= StFinish;
                        job_done <= 1'b1;
                        proc_rst <= 1'b1;
                    end
                end

                // Address was presented on entry; proc_out is valid READ_LAT
                // cycles later and is sampled on the edge after that.
                StReadWait: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    if (lat_cnt == LAT_W'(READ_LAT)) begin
                        out_data  <= proc_out;
                        out_valid <= 1'b1;
                        state     <= StReadOut;
                    end
                end

                StReadOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (k == read_cnt - CNT_W'(1)) begin
                            state    <= StFinish;
                            job_done <= 1'b1;
                            proc_rst <= 1'b1;
                        end else begin
                            k            <= k + CNT_W'(1);
                            mem_addr_out <= ADDR_W'(k + CNT_W'(1));
                            state        <= StReadWait;
                        end
                    end
                end

                StFinish: begin
                    proc_rst <= 1'b1;
                    state    <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
